// File: rtl/inv_ctrl_pkg.sv
// Shared encodings and defaults for the invert arbiter slice.
package inv_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/invert_core.sv
// Combinational WIDTH-bit inverter datapath shared by both requesters.
module invert_core
    import inv_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    // Plain bitwise NOT, no extension or carry
    assign y = ~a;

endmodule

// File: rtl/invert_arbiter.sv
// Two-requester round-robin front end for the shared invert_core.
// One operation in flight: IDLE accepts, CALC computes, DONE holds the result.
module invert_arbiter
    import inv_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    input  logic             out_ready,
    output logic             busy
);

    state_t           state;
    logic             last_id;
    logic             cur_id;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] core_y;
    logic             grant0;
    logic             grant1;

    // Round-robin grant: a lone requester wins, on contention the one not served last
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && (!req1_valid || (last_id == ID_REQ1))) begin
            grant0 = 1'b1;
        end else if (req1_valid) begin
            grant1 = 1'b1;
        end
    end

    // Readies only in IDLE and never while reset is asserted
    assign req0_ready = !rst && (state == ST_IDLE) && grant0;
    assign req1_ready = !rst && (state == ST_IDLE) && grant1;
    assign busy       = !rst && (state != ST_IDLE);

    invert_core #(.WIDTH(WIDTH)) u_core (
        .a (operand),
        .y (core_y)
    );

    // Control FSM with operand capture and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            last_id   <= ID_REQ1;
            cur_id    <= ID_REQ0;
            operand   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= ID_REQ0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant0) begin
                        operand <= req0_data;
                        cur_id  <= ID_REQ0;
                        last_id <= ID_REQ0;
                        state   <= ST_CALC;
                    end else if (grant1) begin
                        operand <= req1_data;
                        cur_id  <= ID_REQ1;
                        last_id <= ID_REQ1;
                        state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    out_data  <= core_y;
                    out_id    <= cur_id;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
